// File: rtl/lc3_memory.sv
// LC-3 main memory: DEPTH x WIDTH word array with combinational read,
// synchronous write and a synchronous clear of every word on reset.
module lc3_memory #(
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 8
) (
    output logic [WIDTH-1:0] mdr_out,
    input  logic             clk,
    input  logic             reset,
    input  logic             memwe,
    input  logic [WIDTH-1:0] mdr,
    input  logic [15:0]      mar
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] index;
    logic                 unused_mar_hi;

    // Upper address bits are dropped, so addresses alias modulo DEPTH.
    assign index         = mar[ADDR_BITS-1:0];
    assign unused_mar_hi = ^mar[15:ADDR_BITS];

    // The read has no write-through path: during a write cycle the old word is visible.
    assign mdr_out = mem[index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memwe) begin
            mem[index] <= mdr;
        end
    end

endmodule

// File: tb/tb_lc3_memory.sv
// Directed and randomized checks of lc3_memory against a word-array model
// indexed by the address taken modulo the memory depth.
module tb_lc3_memory;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        memwe;
    logic [15:0] mdr;
    logic [15:0] mar;
    logic [15:0] mdr_out;

    int vectors;
    int miscompares;

    logic [15:0] model [DEPTH];

    lc3_memory #(.DEPTH(256), .WIDTH(16), .ADDR_BITS(8)) dut (
        .mdr_out(mdr_out),
        .clk    (clk),
        .reset  (reset),
        .memwe  (memwe),
        .mdr    (mdr),
        .mar    (mar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s mar=%h observed=%h expected=%h", tag, mar, got, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a) % DEPTH;
    endfunction

    // One bus cycle: inputs change after the falling edge, the old word is
    // checked before the rising edge and the updated word just after it.
    task automatic cycle(input string tag, input logic rst, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        reset = rst;
        memwe = we;
        mar   = a;
        mdr   = d;
        #1;
        check({tag, "_pre"}, mdr_out, model[widx(a)]);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        end else if (we) begin
            model[widx(a)] = d;
        end
        #1;
        check({tag, "_post"}, mdr_out, model[widx(a)]);
        @(negedge clk);
        reset = 1'b0;
        memwe = 1'b0;
    endtask

    task automatic read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        mar = a;
        #1;
        check(tag, mdr_out, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        memwe = 1'b0;
        mdr   = 16'h0000;
        mar   = 16'h0000;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        @(negedge clk);
        @(negedge clk);

        // Reset for one cycle, then sweep every word.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) read("reset_sweep", 16'(a), 16'h0000);

        // Basic write and read.
        cycle("wr_beef", 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        read("rd_beef", 16'h0010, 16'hBEEF);
        @(negedge clk);
        read("rd_beef_later", 16'h0010, 16'hBEEF);
        read("rd_neighbour", 16'h0011, 16'h0000);

        // Aliasing of the upper address bits.
        cycle("wr_alias", 1'b0, 1'b1, 16'h0105, 16'h1234);
        read("alias_0005", 16'h0005, 16'h1234);
        read("alias_ff05", 16'hFF05, 16'h1234);

        // Read during write shows the old word first.
        cycle("rdw_init", 1'b0, 1'b1, 16'h0020, 16'h0001);
        cycle("rdw", 1'b0, 1'b1, 16'h0020, 16'h0002);
        read("rdw_after", 16'h0020, 16'h0002);

        // Back-to-back writes to one address keep the last value.
        cycle("b2b_1", 1'b0, 1'b1, 16'h0040, 16'h1111);
        cycle("b2b_2", 1'b0, 1'b1, 16'h0040, 16'h2222);
        read("b2b_last", 16'h0040, 16'h2222);

        // Reset wins over a simultaneous write.
        cycle("rst_prio", 1'b1, 1'b1, 16'h0030, 16'hAAAA);
        read("rst_prio_30", 16'h0030, 16'h0000);
        read("rst_clears_10", 16'h0010, 16'h0000);

        // Write enable off: toggling bus values must not disturb stored words.
        cycle("we_off_a", 1'b0, 1'b1, 16'h0050, 16'h5A5A);
        cycle("we_off_b", 1'b0, 1'b1, 16'h0051, 16'hA5A5);
        for (int i = 0; i < 10; i++) begin
            cycle("we_off_toggle", 1'b0, 1'b0, 16'(i[0] ? 16'h0050 : 16'h0051),
                  16'($urandom));
        end
        read("we_off_50", 16'h0050, 16'h5A5A);
        read("we_off_51", 16'h0051, 16'hA5A5);

        // Randomized traffic, mostly in a narrow window to force reuse.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic        we;
            logic        rst;
            a   = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : {8'($urandom), 8'($urandom_range(0, 15))};
            we  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 79) == 0);
            cycle("random", rst, we, a, 16'($urandom));
        end

        // Final sweep of the whole array against the model.
        for (int a = 0; a < DEPTH; a++) read("final_sweep", 16'(a), model[a]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
